// File: rtl/mem32_pkg.sv
// ---------------------------------------------------------------------------
// mem32_pkg
// Shared definitions for the 32-bit memory-access stage:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 reserved)
//   - FSM state encoding (ST_IDLE / ST_REQ / ST_DONE)
//   - default bus-ack watchdog limit
//   - helpers for alignment check, byte enables and store lane replication
// ---------------------------------------------------------------------------
package mem32_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

   // True when the address offset is legal for the access size; the
   // reserved size encoding is always treated as a fault.
   function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] off);
      logic ok_s;
      case (size)
         SZ_BYTE: ok_s = 1'b1;
         SZ_HALF: ok_s = ~off[0];
         SZ_WORD: ok_s = (off == 2'b00);
         default: ok_s = 1'b0;
      endcase
      return ok_s;
   endfunction

   // Little-endian byte enables for the addressed lane(s).
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be_s;
      case (size)
         SZ_BYTE: be_s = 4'b0001 << off;
         SZ_HALF: be_s = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be_s = 4'b1111;
         default: be_s = 4'b0000;
      endcase
      return be_s;
   endfunction

   // Replicate the store operand across all lanes so the bus only has to
   // honour the byte enables.
   function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] wd_s;
      case (size)
         SZ_BYTE: wd_s = {4{data[7:0]}};
         SZ_HALF: wd_s = {2{data[15:0]}};
         default: wd_s = data;
      endcase
      return wd_s;
   endfunction

endpackage

// File: rtl/mem_lane_align32.sv
// ---------------------------------------------------------------------------
// mem_lane_align32
// Combinational load-data aligner: picks the addressed byte/half lane out of
// the bus read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata       in  32  read word from the bus
//   offset      in  2   byte offset of the access (addr[1:0])
//   size        in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   data        out 32  extended load result
// ---------------------------------------------------------------------------
module mem_lane_align32
   import mem32_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection followed by extension according to size and signedness.
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      data   = 32'h0000_0000;
      case (offset)
         2'b00:   byte_s = rdata[7:0];
         2'b01:   byte_s = rdata[15:8];
         2'b10:   byte_s = rdata[23:16];
         2'b11:   byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      half_s = offset[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: data = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
         SZ_HALF: data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
         SZ_WORD: data = rdata;
         default: data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_access32.sv
// ---------------------------------------------------------------------------
// mem_access32
// Memory-access stage of the 32-bit MIPS core. Issues lw/lh/lhu/lb/lbu/sw/sh/sb
// on a word-wide req/ack data bus, stalls the pipeline while the bus is busy
// and returns extended load data for write-back.
// Optional feature: define MEM_TIMEOUT_EN to enable the bus-ack watchdog
// (TIMEOUT_CYCLES REQ cycles without ack abort the access with Bus_error).
// Ports:
//   clock, reset_n                  clock, async active-low reset
//   Mem_valid, MemRead, MemWrite    instruction present / load / store
//   Mem_size, Mem_unsigned          access size, zero-extend load
//   ALU_Result, Read_data_2         effective address, store operand
//   bus_req/we/addr/be/wdata        registered bus request
//   bus_ack, bus_rdata              bus completion and read word
//   Mem_stall                       combinational upstream freeze
//   Read_data, Load_valid           load result and its update pulse
//   Misaligned, Bus_error           fault pulses
// ---------------------------------------------------------------------------
module mem_access32
   import mem32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        Mem_valid,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Mem_size,
   input  logic        Mem_unsigned,
   input  logic [31:0] ALU_Result,
   input  logic [31:0] Read_data_2,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        Mem_stall,
   output logic [31:0] Read_data,
   output logic        Load_valid,
   output logic        Misaligned,
   output logic        Bus_error
);

   state_e      state_r;
   logic [1:0]  size_r;
   logic [1:0]  off_r;
   logic        uns_r;
   logic        accept_s;
   logic        aligned_s;
   logic        tmo_hit_s;
   logic [31:0] lane_data_s;

   // New accesses are only taken when no bus cycle is outstanding.
   assign accept_s  = Mem_valid & (MemRead | MemWrite) &
                      ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign aligned_s = addr_aligned(Mem_size, ALU_Result[1:0]);
   assign Mem_stall = (accept_s & aligned_s) | ((state_r == ST_REQ) & ~bus_ack);

   mem_lane_align32 u_lane (
      .rdata       (bus_rdata),
      .offset      (off_r),
      .size        (size_r),
      .is_unsigned (uns_r),
      .data        (lane_data_s)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] tmo_cnt_r;

   assign tmo_hit_s = (state_r == ST_REQ) & ~bus_ack & (tmo_cnt_r == TMO_LAST);

   // Watchdog: counts REQ cycles, restarts on every aligned accept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s & aligned_s) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_REQ) begin
         tmo_cnt_r <= tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`else
   logic [31:0] unused_tmo_s;
   assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
   assign tmo_hit_s    = 1'b0;
`endif

   // Access FSM with registered bus outputs, load result and fault pulses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         size_r     <= 2'b00;
         off_r      <= 2'b00;
         uns_r      <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'h0000_0000;
         bus_be     <= 4'b0000;
         bus_wdata  <= 32'h0000_0000;
         Read_data  <= 32'h0000_0000;
         Load_valid <= 1'b0;
         Misaligned <= 1'b0;
         Bus_error  <= 1'b0;
      end else begin
         Load_valid <= 1'b0;
         Misaligned <= 1'b0;
         Bus_error  <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (accept_s & aligned_s) begin
                  // Store wins when both MemRead and MemWrite are set.
                  bus_we    <= MemWrite;
                  bus_addr  <= {ALU_Result[31:2], 2'b00};
                  bus_be    <= byte_enables(Mem_size, ALU_Result[1:0]);
                  bus_wdata <= lane_replicate(Mem_size, Read_data_2);
                  size_r    <= Mem_size;
                  off_r     <= ALU_Result[1:0];
                  uns_r     <= Mem_unsigned;
                  bus_req   <= 1'b1;
                  state_r   <= ST_REQ;
               end else if (accept_s) begin
                  Misaligned <= 1'b1;
                  state_r    <= ST_IDLE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we) begin
                     Read_data  <= lane_data_s;
                     Load_valid <= 1'b1;
                  end
                  state_r <= ST_DONE;
               end else if (tmo_hit_s) begin
                  bus_req   <= 1'b0;
                  Bus_error <= 1'b1;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               bus_req <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
